// File: rtl/genesis_ram_arbiter.sv
// Two-master (68K / Z80) arbiter for the shared single-port work RAM, with a
// starvation guard for the Z80. Optional bus-request ports: define Z80_BUSREQ_EN.
module genesis_ram_arbiter #(
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   // Per side, 4-phase handshake: req is a level held until ack=1; ack then
   // stays high until req is seen low, and ack drops before the next grant.
   input  logic              m68_req,
   input  logic              m68_we,
   input  logic [ADDR_W-1:0] m68_addr,
   input  logic [DATA_W-1:0] m68_wdata,
   output logic              m68_ack,
   output logic [DATA_W-1:0] m68_rdata,
   input  logic              z80_req,
   input  logic              z80_we,
   input  logic [ADDR_W-1:0] z80_addr,
   input  logic [DATA_W-1:0] z80_wdata,
   output logic              z80_ack,
   output logic [DATA_W-1:0] z80_rdata,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
`ifdef Z80_BUSREQ_EN
   input  logic              z80_busreq,
   output logic              z80_busack,
`endif
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESP    = 2'd2,
      RELEASE = 2'd3
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t            state, state_d;
   logic              owner_z, owner_z_d;
   logic              op_we, op_we_d;
   logic [3:0]        streak, streak_d;
   logic [3:0]        streak_inc;
   logic              ram_en_d, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_d;
   logic              m68_ack_d, z80_ack_d;
   logic [DATA_W-1:0] m68_rdata_d, z80_rdata_d;
   logic              z_block, z_eff, owner_req;

`ifdef Z80_BUSREQ_EN
   logic busack_d;

   // A raised busreq masks the Z80 on the very edge busack rises, so the
   // 68K never sees a Z80 grant slip in alongside its bus acknowledge.
   assign z_block = z80_busack | ((state == IDLE) & z80_busreq);

   always_comb begin
      busack_d = z80_busack;
      if (!z80_busreq)
         busack_d = 1'b0;
      else if (state == IDLE)
         busack_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         z80_busack <= 1'b0;
      else
         z80_busack <= busack_d;
   end
`else
   assign z_block = 1'b0;
`endif

   assign z_eff      = z80_req & ~z_block;
   assign owner_req  = owner_z ? z80_req : m68_req;
   assign streak_inc = (streak == 4'hF) ? streak : streak + 4'd1;
   assign dbg_state  = state;

   always_comb begin
      state_d     = state;
      owner_z_d   = owner_z;
      op_we_d     = op_we;
      streak_d    = streak;
      ram_en_d    = 1'b0;
      ram_we_d    = ram_we;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      m68_ack_d   = m68_ack;
      z80_ack_d   = z80_ack;
      m68_rdata_d = m68_rdata;
      z80_rdata_d = z80_rdata;

      case (state)
         IDLE: begin
            if (m68_req || z_eff) begin
               if (z_eff && (!m68_req || streak >= STARVE_LIM)) begin
                  owner_z_d   = 1'b1;
                  streak_d    = 4'd0;
                  op_we_d     = z80_we;
                  ram_we_d    = z80_we;
                  ram_addr_d  = z80_addr;
                  ram_wdata_d = z80_wdata;
               end else begin
                  owner_z_d   = 1'b0;
                  // Only a 68K win over a waiting Z80 counts toward starvation.
                  streak_d    = z_eff ? streak_inc : 4'd0;
                  op_we_d     = m68_we;
                  ram_we_d    = m68_we;
                  ram_addr_d  = m68_addr;
                  ram_wdata_d = m68_wdata;
               end
               ram_en_d = 1'b1;
               state_d  = ACCESS;
            end
         end
         ACCESS: begin
            ram_we_d = 1'b0;
            state_d  = RESP;
         end
         RESP: begin
            if (owner_z) begin
               z80_ack_d = 1'b1;
               if (!op_we) z80_rdata_d = ram_rdata;
            end else begin
               m68_ack_d = 1'b1;
               if (!op_we) m68_rdata_d = ram_rdata;
            end
            state_d = RELEASE;
         end
         RELEASE: begin
            if (!owner_req) begin
               m68_ack_d = 1'b0;
               z80_ack_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifdef Z80_BUSREQ_EN
      if (z80_busack) streak_d = 4'd0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner_z   <= 1'b0;
         op_we     <= 1'b0;
         streak    <= 4'd0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         m68_ack   <= 1'b0;
         z80_ack   <= 1'b0;
         m68_rdata <= '0;
         z80_rdata <= '0;
      end else begin
         state     <= state_d;
         owner_z   <= owner_z_d;
         op_we     <= op_we_d;
         streak    <= streak_d;
         ram_en    <= ram_en_d;
         ram_we    <= ram_we_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         m68_ack   <= m68_ack_d;
         z80_ack   <= z80_ack_d;
         m68_rdata <= m68_rdata_d;
         z80_rdata <= z80_rdata_d;
      end
   end

endmodule
